pipeline_sched: RTL and testbench
=================================

# pipeline_sched

Round-robin scheduler that shares one fixed-depth data pipeline between `p_num_req` requesters. It accepts at most one request per cycle and tags the data with the requester index. The data and tag travel through `p_depth` register stages. Issue is throttled by a credit counter that tracks free space in the downstream consumer. The block sits between the requester ports and the consumer, and replaces a bare single-source pipeline wherever several sources feed one datapath.

## Interface
- `p_width`, 32, data width per requester
- `p_num_req`, 4, number of requesters (≥2)
- `p_depth`, 3, pipeline stages between accept and output (≥1)
- `p_credits`, 4, downstream buffer entries (≥1)
- Ports, one per line:
  - `i_clk`  in  1  clock; the only clock
  - `i_rst`  in  1  reset, synchronous, active-high
  - `i_req_valid`  in  `p_num_req`  per-requester request
  - `i_req_data`  in  `p_num_req*p_width`  requester r occupies bits `[r*p_width +: p_width]`
  - `o_req_ready`  out  `p_num_req`  one-hot-or-zero grant
  - `o_valid`  out  1  output data valid
  - `o_data`  out  `p_width`  output data
  - `o_id`  out  `$clog2(p_num_req)`  index of the originating requester
  - `i_credit_return`  in  1  one-cycle pulse; the consumer freed one entry
  - `o_credit_err`  out  1  sticky overflow flag

## Operation
- Transfer on requester r: `i_req_valid[r] && o_req_ready[r]` in the same cycle.
- `o_req_ready` is combinational from `i_req_valid`, the priority pointer and the credit count. It is all-zero when credits == 0.
- Round-robin selection:
  - Search starts at pointer `ptr` and proceeds `ptr, ptr+1, …`, wrapping modulo `p_num_req`.
  - The first valid requester found is granted.
  - After a transfer from r, `ptr` becomes `(r+1) mod p_num_req`.
  - With no transfer, `ptr` holds.
- Pipeline contents:
  - Stage 0 captures valid, data and id of the transfer.
  - Stage k captures stage k-1 every cycle. There is no stall: the pipeline always advances.
  - A cycle with no transfer inserts a bubble (valid=0).
- `o_valid`, `o_data` and `o_id` are driven from stage `p_depth-1`.
- Credit counter, width `$clog2(p_credits+1)`:
  - Transfer only: decrement.
  - Return only: increment.
  - Both in the same cycle: unchanged.
- Credit return while the count == `p_credits` and no transfer occurs:
  - The count stays at `p_credits`.
  - `o_credit_err` is set and stays set until reset.
- Reset:
  - Credit count = `p_credits`.
  - `ptr` = 0.
  - All stage valids = 0.
  - `o_valid` = 0, `o_data` = 0, `o_id` = 0, `o_credit_err` = 0.
  - Reset mid-operation discards all in-flight data. No output is produced for it.
- Data and id of bubble stages are don't-care in the RTL, except after reset, when they are 0.

## Timing
- Latency: transfer in cycle t gives `o_valid` = 1 in cycle t+`p_depth` with the same data and id.
- Throughput: one transfer per cycle while credits > 0.
- A credit returned in cycle t is usable for a grant in cycle t+1.
- A grant in the same cycle as a return, with count == 0, is not allowed. The count is 0 when grant is evaluated.
- `ptr` and the credit count update on the `i_clk` rising edge after the transfer.
- `i_rst` takes priority over every other update in the same cycle.

## Configuration
- Macro: `PIPELINE_SCHED_PRIO_EN`.
- Defined:
  - Requester 0 has strict priority. It is granted whenever `i_req_valid[0]` = 1 and credits > 0.
  - Otherwise round-robin runs over requesters 1…`p_num_req`-1.
  - `ptr` is not updated by requester-0 transfers.
- Undefined:
  - Pure round-robin over all requesters as described in Operation.
- All other behaviour, including latency, credits and reset values, is identical in both builds.

## Test plan
- **Reset and single request**
  - Stimulus: reset, then `i_req_valid` = 4'b0100 with data `0xA5A5_0002` for one cycle.
  - Required response: `o_req_ready` = 4'b0100. Three cycles later `o_valid` = 1, `o_data` = `0xA5A5_0002`, `o_id` = 2. Credit count = 3.
- **Round-robin fairness**
  - Stimulus: all 4 requesters valid continuously, `i_credit_return` pulsed every cycle after the first.
  - Required response: grants in order 0,1,2,3,0,1… and the `o_id` sequence matches. `o_credit_err` stays 0.
- **Credit exhaustion**
  - Stimulus: requester 1 valid continuously, no returns.
  - Required response: exactly 4 transfers, then `o_req_ready` = 0. A single `i_credit_return` pulse allows exactly one further transfer, in the next cycle.
- **Simultaneous issue and return**
  - Stimulus: credits = 2, a transfer and a return in the same cycle.
  - Required response: the count remains 2.
- **Credit overflow and reset mid-flight**
  - Stimulus: return pulse while the count = 4; then, with 3 items in flight, assert `i_rst` for one cycle.
  - Required response: after the pulse, `o_credit_err` = 1. After reset, `o_valid` stays 0 for all following cycles until a new request, credits = 4, and `o_credit_err` = 0.
- **`PIPELINE_SCHED_PRIO_EN` build**
  - Stimulus: requesters 0 and 2 valid continuously, with credits kept replenished.
  - Required response: every grant goes to 0. Once requester 0 drops, requester 2 is granted the next cycle.

Source files
------------

// File: rtl/pipeline_sched.sv
// pipeline_sched: round-robin scheduler feeding one fixed-depth data pipeline.
// Each accepted request is tagged with its requester index and travels
// through p_depth register stages. Issue is gated by a downstream credit count.
// Optional build macro PIPELINE_SCHED_PRIO_EN: requester 0 gets strict
// priority, and round-robin runs over the remaining requesters.
module pipeline_sched #(
    parameter int p_width   = 32,
    parameter int p_num_req = 4,
    parameter int p_depth   = 3,
    parameter int p_credits = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [p_num_req-1:0]           i_req_valid,
    input  logic [p_num_req*p_width-1:0]   i_req_data,
    output logic [p_num_req-1:0]           o_req_ready,
    output logic                           o_valid,
    output logic [p_width-1:0]             o_data,
    output logic [$clog2(p_num_req)-1:0]   o_id,
    input  logic                           i_credit_return,
    output logic                           o_credit_err
);

    localparam int ID_W = $clog2(p_num_req);
    localparam int CW   = $clog2(p_credits + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(p_credits);

    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]      credit_reg, credit_next;
    logic               err_reg, err_next;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [p_width-1:0] req_data_arr [p_num_req];
    logic [p_width-1:0] stage_data_in;

    logic               valid_reg [p_depth];
    logic [p_width-1:0] data_reg  [p_depth];
    logic [ID_W-1:0]    id_reg    [p_depth];

    // Split the flat request bus into one word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < p_num_req; gi++) begin : g_req_split
            assign req_data_arr[gi] = i_req_data[gi*p_width +: p_width];
        end
    endgenerate

    // Grant selection: scan from ptr with wrap; nothing is granted without credit.
    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        o_req_ready = '0;
        if (credit_reg != '0) begin
`ifdef PIPELINE_SCHED_PRIO_EN
            if (i_req_valid[0]) begin
                grant_any = 1'b1;
                grant_idx = '0;
            end
`endif
            for (int i = 0; i < p_num_req; i++) begin
                cand = ID_W'((int'(ptr_reg) + i) % p_num_req);
`ifdef PIPELINE_SCHED_PRIO_EN
                if (!grant_any && (cand != '0) && i_req_valid[cand]) begin
`else
                if (!grant_any && i_req_valid[cand]) begin
`endif
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    // Next pointer, credit count and sticky overflow flag.
    always_comb begin
        ptr_next    = ptr_reg;
        credit_next = credit_reg;
        err_next    = err_reg;
`ifdef PIPELINE_SCHED_PRIO_EN
        if (grant_any && (grant_idx != '0)) begin
`else
        if (grant_any) begin
`endif
            ptr_next = ID_W'((int'(grant_idx) + 1) % p_num_req);
        end
        case ({grant_any, i_credit_return})
            2'b10: credit_next = credit_reg - CW'(1);
            2'b01: begin
                if (credit_reg == CREDIT_MAX) begin
                    err_next = 1'b1;
                end else begin
                    credit_next = credit_reg + CW'(1);
                end
            end
            default: credit_next = credit_reg;
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_reg    <= '0;
            credit_reg <= CREDIT_MAX;
            err_reg    <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            credit_reg <= credit_next;
            err_reg    <= err_next;
        end
    end

    // Bubbles carry zero data so idle output words are deterministic.
    assign stage_data_in = grant_any ? req_data_arr[grant_idx] : '0;

    // Data pipeline: always advances, stage 0 takes the current transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < p_depth; k++) begin
                valid_reg[k] <= 1'b0;
                data_reg[k]  <= '0;
                id_reg[k]    <= '0;
            end
        end else begin
            valid_reg[0] <= grant_any;
            data_reg[0]  <= stage_data_in;
            id_reg[0]    <= grant_any ? grant_idx : '0;
            for (int k = 1; k < p_depth; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                data_reg[k]  <= data_reg[k-1];
                id_reg[k]    <= id_reg[k-1];
            end
        end
    end

    assign o_valid      = valid_reg[p_depth-1];
    assign o_data       = data_reg[p_depth-1];
    assign o_id         = id_reg[p_depth-1];
    assign o_credit_err = err_reg;

endmodule

// File: tb/tb_pipeline_sched.sv
// Testbench for pipeline_sched: directed table, hand-written corner sequences
// and randomized traffic against a behavioural model of the scheduler.
module tb_pipeline_sched;
    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 3;
    localparam int C = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_valid;
    logic [N*W-1:0] i_req_data;
    logic [N-1:0]   o_req_ready;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic [1:0]     o_id;
    logic           i_credit_return;
    logic           o_credit_err;

    pipeline_sched #(.p_width(W), .p_num_req(N), .p_depth(D), .p_credits(C)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_valid(o_valid),
        .o_data(o_data), .o_id(o_id), .i_credit_return(i_credit_return),
        .o_credit_err(o_credit_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         rst;
        logic [3:0] v;
        bit         ret;
        logic [3:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int          m_ptr;
    int          m_cred;
    bit          m_err;
    bit          mv  [D];
    logic [31:0] md  [D];
    int          mid [D];

    logic [3:0]  ready_seen;
    logic [31:0] data_word [N];
    bit          use_fixed;
    vec_t        tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rst, input logic [3:0] v, input bit ret, input logic [3:0] exp);
        vec_t r;
        r.rst = rst; r.v = v; r.ret = ret; r.exp = exp;
        return r;
    endfunction

    // Winner = valid requester at the smallest rotational distance from ptr.
    function automatic int model_grant(input logic [3:0] v);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N + 1;
        if (m_cred == 0) return -1;
`ifdef PIPELINE_SCHED_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int r = 0; r < N; r++) begin
`ifdef PIPELINE_SCHED_PRIO_EN
            if (r == 0) continue;
`endif
            if (v[r]) begin
                d = (r - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = r;
                end
            end
        end
        return best;
    endfunction

    function automatic void model_reset();
        m_ptr  = 0;
        m_cred = C;
        m_err  = 1'b0;
        for (int k = 0; k < D; k++) begin
            mv[k] = 1'b0; md[k] = '0; mid[k] = 0;
        end
    endfunction

    // One clock cycle: drive, check mid-cycle against the model, advance model.
    task automatic cycle(input logic [3:0] v, input bit ret, input bit rst);
        int         g;
        logic [3:0] exp_rdy;
        for (int r = 0; r < N; r++) begin
            data_word[r] = use_fixed ? (32'hA5A5_0000 + 32'(r)) : $urandom;
            i_req_data[r*W +: W] = data_word[r];
        end
        i_req_valid     = v;
        i_credit_return = ret;
        i_rst           = rst;
        #4;
        g = model_grant(v);
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        ready_seen = o_req_ready;
        check("ready", o_req_ready, exp_rdy);
        check("valid", o_valid, mv[D-1]);
        if (mv[D-1]) begin
            check("data", o_data, md[D-1]);
            check("id", o_id, mid[D-1]);
        end
        check("err", o_credit_err, m_err);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = D - 1; k > 0; k--) begin
                mv[k] = mv[k-1]; md[k] = md[k-1]; mid[k] = mid[k-1];
            end
            mv[0]  = (g >= 0);
            md[0]  = (g >= 0) ? data_word[g] : 32'h0;
            mid[0] = (g >= 0) ? g : 0;
`ifdef PIPELINE_SCHED_PRIO_EN
            if (g > 0) m_ptr = (g + 1) % N;
`else
            if (g >= 0) m_ptr = (g + 1) % N;
`endif
            if (g >= 0 && !ret) m_cred--;
            else if (g < 0 && ret) begin
                if (m_cred == C) m_err = 1'b1;
                else m_cred++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_credit_return = 1'b0;
        use_fixed = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        i_rst = 1'b0;

        // Reset state
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, 32'h0);
        check("rst_id", o_id, 2'd0);
        check("rst_err", o_credit_err, 1'b0);

        // Single request from requester 2, output D cycles later
        cycle(4'b0100, 1'b0, 1'b0);
        check("single_ready", ready_seen, 4'b0100);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);
        check("single_out_valid", o_valid, 1'b1);
        check("single_out_data", o_data, 32'hA5A5_0002);
        check("single_out_id", o_id, 2'd2);
        // Three credits remain
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0010, 1'b0, 1'b0);
            check("cred3_ready", ready_seen, (i < 3) ? 4'b0010 : 4'b0000);
        end

        // Directed table
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0010, 0, 4'b0010));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0010));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001));
        for (int i = 1; i < 8; i++) begin
`ifdef PIPELINE_SCHED_PRIO_EN
            tbl.push_back(mk(0, 4'b1111, 1, 4'b0001));
`else
            tbl.push_back(mk(0, 4'b1111, 1, 4'(1 << (i % 4))));
`endif
        end
        tbl.push_back(mk(1, 4'b0000, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0101, 0, 4'b0001));
`ifdef PIPELINE_SCHED_PRIO_EN
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0001));
`else
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0100));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0100));
`endif
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100));
        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].ret, tbl[i].rst);
            check($sformatf("tbl%0d_ready", i), ready_seen, tbl[i].exp);
        end

        // Credit overflow, then reset with three items in flight
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("ovf_err_set", o_credit_err, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        check("rst_err_clear", o_credit_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, 1'b0, 1'b0);
            check("flush_valid", o_valid, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0010, 1'b0, 1'b0);
            check("post_rst_cred", ready_seen, (i < 4) ? 4'b0010 : 4'b0000);
        end

        // Randomized traffic against the model
        use_fixed = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'($urandom % 2), ($urandom % 50) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
